// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Stall and flush sequencer for the 5-stage pipeline. It catches the hazards
// that the forwarding unit cannot cover (load-use, decode-resolved operands
// still coming from a load) and taken-branch redirects. It then drives the
// PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush.
// Optional feature macro: HAZARD_STALL_COUNT_EN adds the stall_count and
// flush_count event counters.
module hazard_stall_controller #(
  parameter int         BR_FLUSH_CYCLES = 1,
  parameter logic [4:0] ZERO_REG        = 5'b11111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  if_idRn,
  input  logic [4:0]  if_idRm,
  input  logic [4:0]  if_idRd,
  input  logic        dec_usesRm,
  input  logic        dec_rdsrc,
  input  logic        dec_early,
  input  logic        br_taken,
  input  logic [4:0]  exRd,
  input  logic        exMemRead,
  input  logic [4:0]  memRd,
  input  logic        memMemRead,
`ifdef HAZARD_STALL_COUNT_EN
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
`endif
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        stalled
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL2 = 2'd1,
    STALL1 = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  // Counter value loaded on a taken branch; the RUN cycle itself is the first flush slot
  localparam logic [1:0] FLUSH_INIT = 2'(BR_FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       ex_hit, mem_hit;

  // Hazard detection; the zero register never carries a real dependency
  always_comb begin
    ex_hit  = exMemRead && (exRd != ZERO_REG) &&
              ((exRd == if_idRn) ||
               (dec_usesRm && (exRd == if_idRm)) ||
               (dec_rdsrc && (exRd == if_idRd)));
    mem_hit = memMemRead && (memRd != ZERO_REG) && dec_early && (memRd == if_idRd);
  end

  // State and flush counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state logic; hazards outrank a taken branch since the branch re-resolves later
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN: begin
        if (ex_hit && dec_early) begin
          state_d = STALL1;
        end else if (ex_hit || mem_hit) begin
          state_d = RUN;
        end else if (br_taken && (BR_FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_INIT;
        end
      end
      STALL1: state_d = RUN;
      STALL2: state_d = STALL1;
      FLUSH: begin
        fcnt_d = fcnt_q - 2'd1;
        if (fcnt_q <= 2'd1) begin
          state_d = RUN;
          fcnt_d  = 2'd0;
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = 2'd0;
      end
    endcase
  end

  // Output logic: Mealy in RUN, Moore elsewhere, forced to pass-through while in reset
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    stalled      = 1'b0;
    if (reset) begin
      stalled = (state_q != RUN);
      case (state_q)
        RUN: begin
          if (ex_hit || mem_hit) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (br_taken) begin
            if_id_flush = 1'b1;
          end
        end
        STALL1, STALL2: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
        FLUSH: begin
          if_id_flush = 1'b1;
        end
        default: begin
          pc_write = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Saturating event counters for bubbles and flushes
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (id_ex_bubble && (stall_count_q != 32'hFFFFFFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
    if (if_id_flush && (flush_count_q != 32'hFFFFFFFF)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller
// Directed bench for hazard_stall_controller with BR_FLUSH_CYCLES=2. Each step
// pushes its expected output vector into a scoreboard queue. The vector is
// popped and compared on the following falling edge.
module tb_hazard_stall_controller;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic bubble;
    logic flush;
    logic stalled;
  } exp_t;

  localparam exp_t E_IDLE   = 5'b11000;
  localparam exp_t E_HOLD   = 5'b00100;
  localparam exp_t E_HOLDST = 5'b00101;
  localparam exp_t E_FLUSH  = 5'b11010;
  localparam exp_t E_FLUSHS = 5'b11011;

  logic       clk;
  logic       reset;
  logic [4:0] if_idRn, if_idRm, if_idRd, exRd, memRd;
  logic       dec_usesRm, dec_rdsrc, dec_early, br_taken, exMemRead, memMemRead;
  logic       pc_write, if_id_write, id_ex_bubble, if_id_flush, stalled;
`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_count, flush_count;
`endif

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks;
  int    errors;
  int    model_stall;
  int    model_flush;

  hazard_stall_controller #(
    .BR_FLUSH_CYCLES(2),
    .ZERO_REG(5'b11111)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_idRn(if_idRn),
    .if_idRm(if_idRm),
    .if_idRd(if_idRd),
    .dec_usesRm(dec_usesRm),
    .dec_rdsrc(dec_rdsrc),
    .dec_early(dec_early),
    .br_taken(br_taken),
    .exRd(exRd),
    .exMemRead(exMemRead),
    .memRd(memRd),
    .memMemRead(memMemRead),
`ifdef HAZARD_STALL_COUNT_EN
    .stall_count(stall_count),
    .flush_count(flush_count),
`endif
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush),
    .stalled(stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it against the live outputs
  task automatic checkOutput();
    exp_t  exp;
    exp_t  obs;
    string tag;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: observed=empty required=entry");
      return;
    end
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, stalled};
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b required=%b (pc,ifid,bub,flush,stalled)", tag, obs, exp);
    end
`ifdef HAZARD_STALL_COUNT_EN
    checks++;
    assert (stall_count === 32'(model_stall)) else begin
      errors++;
      $error("[TB] FAIL %s stall_count: observed=%0d required=%0d", tag, stall_count, model_stall);
    end
    checks++;
    assert (flush_count === 32'(model_flush)) else begin
      errors++;
      $error("[TB] FAIL %s flush_count: observed=%0d required=%0d", tag, flush_count, model_flush);
    end
`endif
  endtask

  // Queue the expectation for the inputs already driven, check, then advance one cycle
  task automatic applyStimulus(input string tag, input exp_t exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    checkOutput();
    if (reset) begin
      if (exp.bubble) model_stall++;
      if (exp.flush)  model_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    if_idRn    = 5'd0;
    if_idRm    = 5'd0;
    if_idRd    = 5'd0;
    exRd       = 5'd0;
    memRd      = 5'd0;
    dec_usesRm = 1'b0;
    dec_rdsrc  = 1'b0;
    dec_early  = 1'b0;
    br_taken   = 1'b0;
    exMemRead  = 1'b0;
    memMemRead = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    model_stall = 0;
    model_flush = 0;
    clearInputs();

    // Reset forces pass-through outputs even with a hazard and a branch present
    reset     = 1'b0;
    exMemRead = 1'b1;
    exRd      = 5'd5;
    if_idRn   = 5'd5;
    br_taken  = 1'b1;
    applyStimulus("reset_forced", E_IDLE);

    reset = 1'b1;
    clearInputs();
    applyStimulus("idle_after_reset", E_IDLE);

    // Single load-use bubble, then recovery
    exMemRead = 1'b1; exRd = 5'd5; if_idRn = 5'd5;
    applyStimulus("load_use_rn", E_HOLD);
    exMemRead = 1'b0;
    applyStimulus("load_use_clear", E_IDLE);

    // Zero register never hazards, on either the ex or the mem path
    clearInputs();
    exMemRead = 1'b1; exRd = 5'd31; if_idRn = 5'd31;
    applyStimulus("zero_reg_ex", E_IDLE);
    clearInputs();
    memMemRead = 1'b1; memRd = 5'd31; if_idRd = 5'd31; dec_early = 1'b1;
    applyStimulus("zero_reg_mem", E_IDLE);

    // Rm only counts when the instruction really reads it
    clearInputs();
    exMemRead = 1'b1; exRd = 5'd7; if_idRm = 5'd7; if_idRn = 5'd1; dec_usesRm = 1'b1;
    applyStimulus("load_use_rm", E_HOLD);
    dec_usesRm = 1'b0;
    applyStimulus("rm_immediate", E_IDLE);

    // Rd as a source is ignored unless dec_rdsrc is set
    clearInputs();
    exMemRead = 1'b1; exRd = 5'd9; if_idRd = 5'd9; if_idRn = 5'd1;
    applyStimulus("rd_not_source", E_IDLE);

    // Mem-stage load feeding a decode-resolved branch: one bubble, stay in RUN
    clearInputs();
    memMemRead = 1'b1; memRd = 5'd4; if_idRd = 5'd4; dec_early = 1'b1;
    applyStimulus("mem_hit_hold", E_HOLD);
    memMemRead = 1'b0;
    applyStimulus("mem_hit_clear", E_IDLE);

    // CBZ on a load in EX: RUN hold, STALL1 hold, then exactly two bubbles
    clearInputs();
    dec_early = 1'b1; dec_rdsrc = 1'b1; exMemRead = 1'b1; exRd = 5'd3; if_idRd = 5'd3; if_idRn = 5'd1;
    applyStimulus("cbz_hold_run", E_HOLD);
    exMemRead = 1'b0; memMemRead = 1'b1; memRd = 5'd3;
    applyStimulus("cbz_hold_stall1", E_HOLDST);
    memMemRead = 1'b0;
    applyStimulus("cbz_resume", E_IDLE);

    // Same CBZ but the load still sits in MEM on return to RUN: third hold
    exMemRead = 1'b1; memMemRead = 1'b0; exRd = 5'd3;
    applyStimulus("cbz2_hold_run", E_HOLD);
    exMemRead = 1'b0; memMemRead = 1'b1; memRd = 5'd3;
    applyStimulus("cbz2_hold_stall1", E_HOLDST);
    applyStimulus("cbz2_third_hold", E_HOLD);
    clearInputs();
    applyStimulus("cbz2_resume", E_IDLE);

    // Taken branch: two flush cycles, br_taken in FLUSH ignored
    br_taken = 1'b1;
    applyStimulus("branch_flush_run", E_FLUSH);
    applyStimulus("branch_flush_fsm", E_FLUSHS);
    br_taken = 1'b0;
    applyStimulus("branch_done", E_IDLE);

    // Hazard outranks a taken branch in the same cycle
    exMemRead = 1'b1; exRd = 5'd12; if_idRn = 5'd12; br_taken = 1'b1;
    applyStimulus("priority_hold", E_HOLD);
    clearInputs();
    applyStimulus("priority_clear", E_IDLE);

    // Reset in the middle of a flush aborts it immediately
    br_taken = 1'b1;
    applyStimulus("pre_reset_flush", E_FLUSH);
    reset       = 1'b0;
    model_stall = 0;
    model_flush = 0;
    applyStimulus("reset_mid_flush", E_IDLE);
    reset    = 1'b1;
    br_taken = 1'b0;
    applyStimulus("after_reset_release", E_IDLE);

    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: observed=%0d required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Stall and flush sequencer for the 5-stage pipeline. Sits beside the forwarding unit.
- Detects hazards that forwarding cannot cover:
  - load-use hazards;
  - CBZ/BR/STUR operands still in flight from a load;
  - taken-branch redirects.
- Drives the PC write enable, the IF/ID write enable, the ID/EX bubble insert and the IF/ID flush.
- A small FSM holds the pipeline for multi-cycle stalls and multi-cycle flushes.

Parameters:
- BR_FLUSH_CYCLES, 1: number of cycles if_id_flush stays asserted after a taken branch (legal range 1-3).
- ZERO_REG, 5'b11111: architectural zero register. It never causes a hazard.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low. 0 = reset asserted.
- if_idRn  in  5  decode Rn
- if_idRm  in  5  decode Rm
- if_idRd  in  5  decode Rd; this is the source register for CBZ/BR/STUR
- dec_usesRm  in  1  decode instruction reads Rm (not immediate)
- dec_rdsrc  in  1  decode instruction reads Rd as a source (CBZ, BR, STUR)
- dec_early  in  1  decode instruction resolves in decode (CBZ, BR)
- br_taken  in  1  decode-stage branch resolved taken this cycle
- exRd  in  5  execute-stage Rd
- exMemRead  in  1  execute-stage instruction is LDUR
- memRd  in  5  memory-stage Rd
- memMemRead  in  1  memory-stage instruction is LDUR
- pc_write  out  1  1 = PC updates
- if_id_write  out  1  1 = IF/ID register loads
- id_ex_bubble  out  1  1 = ID/EX loads a NOP (all control signals zero)
- if_id_flush  out  1  1 = IF/ID loads a NOP
- stalled  out  1  1 = FSM not in RUN (debug)

Behaviour:
Hazard terms (combinational):
- ex_hit = exMemRead & exRd!=ZERO_REG & (exRd==if_idRn | (dec_usesRm & exRd==if_idRm) | (dec_rdsrc & exRd==if_idRd))
- mem_hit = memMemRead & memRd!=ZERO_REG & dec_early & memRd==if_idRd

FSM states: RUN, STALL2, STALL1, FLUSH. Registered state; a 2-bit flush counter fcnt.

RUN:
- ex_hit & dec_early: hold this cycle, go to STALL1. Total of 2 bubbles, because the load value must reach WB before decode-stage resolution.
- else ex_hit | mem_hit: hold this cycle, stay in RUN. Re-evaluate next cycle; the load has advanced, so the hazard clears. 1 bubble.
- else br_taken: assert if_id_flush. If BR_FLUSH_CYCLES>1, go to FLUSH with fcnt=BR_FLUSH_CYCLES-1.
- else: no action.

STALL1:
- Hold for one cycle, return to RUN.
- Hazard re-evaluated in RUN; mem_hit now normally clears.

STALL2:
- Reserved encoding; transitions to STALL1.
- Unreachable under current rules. Any illegal state also goes to RUN.

FLUSH:
- if_id_flush=1, pc_write=1, if_id_write=1.
- Decrement fcnt; go to RUN when fcnt==1 on entry.
- br_taken is ignored while in FLUSH, because the flushed slots carry no valid branch.

Output rules:
- "Hold" means pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
- Priority: a hazard stall beats br_taken in the same cycle. A branch whose operand is unresolved is not taken yet; the branch re-resolves after the stall.
- Latency: outputs respond in the same cycle as the hazard inputs (Mealy in RUN, Moore in other states).
- Defaults: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0.
- stalled = (state!=RUN).

Reset:
- While reset=0, all outputs are forced to pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, stalled=0, regardless of inputs.
- State=RUN, fcnt=0.
- Reset asserted mid-stall or mid-flush aborts immediately. There is no residual hold after release.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- When defined:
  - Adds output stall_count (32 bits). It increments on every clk edge where id_ex_bubble=1, saturating at 32'hFFFFFFFF.
  - Adds output flush_count (32 bits). It increments on every edge where if_id_flush=1, with the same saturation.
  - Both counters clear to 0 on reset.
- When undefined: neither port nor any counter logic exists; the remaining behaviour is identical.

Test Plan:
- Load-use: exMemRead=1, exRd=5, if_idRn=5, dec_early=0 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. Next cycle exMemRead=0 -> defaults restored, stalled=0 throughout.
- Zero register: exMemRead=1, exRd=31, if_idRn=31 -> no stall. Same check with memRd=31 for mem_hit -> no stall.
- CBZ on load: dec_early=1, dec_rdsrc=1, exMemRead=1, exRd=3, if_idRd=3 -> hold in RUN cycle, hold in STALL1 (stalled=1), then in RUN with memMemRead=1, memRd=3 -> third hold only if mem_hit. Bench checks exactly 2 bubbles when mem_hit is deasserted.
- Branch flush: BR_FLUSH_CYCLES=2, br_taken=1, no hazard -> if_id_flush=1 for exactly 2 cycles, pc_write=1 both cycles. br_taken=1 in the second cycle is ignored.
- Priority: ex_hit=1 and br_taken=1 together -> hold asserted, if_id_flush=0.
- Reset mid-flush: reset=0 during FLUSH -> outputs immediately at reset values. After release with no hazards, if_id_flush=0. With HAZARD_STALL_COUNT_EN, stall_count=0 and flush_count=0.
